cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter NCORES, default 2: number of cores, each owning one icache channel and one dcache channel; legal range 1..8.
REQ-002 Parameter AW, default 32: address width in bits.
REQ-003 Parameter DW, default 32: data word width in bits.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 nRST  in  1  reset, synchronous and active-low.
REQ-006 iREN  in  NCORES  per-core instruction read request.
REQ-007 iaddr  in  NCORES x AW  per-core instruction address.
REQ-008 dREN  in  NCORES  per-core data read request.
REQ-009 dWEN  in  NCORES  per-core data write request.
REQ-010 daddr  in  NCORES x AW  per-core data address.
REQ-011 dstore  in  NCORES x DW  per-core write data.
REQ-012 iwait  out  NCORES  per-core instruction stall; low for exactly the completing cycle.
REQ-013 dwait  out  NCORES  per-core data stall; low for exactly the completing cycle.
REQ-014 iload  out  NCORES x DW  per-core instruction read data.
REQ-015 dload  out  NCORES x DW  per-core data read data.
REQ-016 ramREN  out  1  memory read strobe.
REQ-017 ramWEN  out  1  memory write strobe.
REQ-018 ramaddr  out  AW  memory address.
REQ-019 ramstore  out  DW  memory write data.
REQ-020 ramload  in  DW  memory read data.
REQ-021 ramrdy  in  1  memory access completes this cycle.

Function
REQ-022 The block SHALL implement FSM states IDLE and ACCESS; IDLE -> ACCESS when any request is pending; ACCESS -> IDLE on completion or abort.
REQ-023 In IDLE, the grant SHALL be latched from the current requests; ram strobes SHALL be low in IDLE.
REQ-024 Data channels (dREN or dWEN) SHALL win over all instruction channels.
REQ-025 Within a class, the winner SHALL be the first requesting core at or after the class round-robin pointer, scanning upward and wrapping modulo NCORES.
REQ-026 If dREN and dWEN are both high on one core, the access SHALL be treated as a write.
REQ-027 In ACCESS, ramREN/ramWEN/ramaddr/ramstore SHALL be driven combinationally from the granted channel's live inputs.
REQ-028 In an ACCESS cycle with ramrdy=1, the granted channel's wait SHALL be low, its load SHALL equal ramload, and the FSM SHALL return to IDLE.
REQ-029 On completion, the class pointer SHALL advance to granted core + 1, wrapping NCORES-1 -> 0; the other class pointer SHALL be unchanged.
REQ-030 Minimum latency SHALL be 2 cycles: request seen in IDLE, then completion in the first ACCESS cycle if ramrdy=1.
REQ-031 If the granted channel drops its request while in ACCESS, the block SHALL abort: strobes low that cycle, return to IDLE, no wait pulse, pointers unchanged.
REQ-032 All non-granted waits SHALL be high whenever that channel requests; a non-requesting channel's wait SHALL be high.
REQ-033 Non-granted load outputs SHALL be 0.
REQ-034 ramrdy in IDLE SHALL be ignored.
REQ-035 Requests arriving during ACCESS SHALL wait; back-to-back transactions SHALL have one IDLE cycle between them.

Reset
REQ-036 With nRST=0 at a rising CLK edge: state=IDLE, both pointers=0, grant cleared.
REQ-037 Outputs after reset SHALL be: ram strobes 0, ramaddr 0, ramstore 0, all waits 1, all loads 0.
REQ-038 Reset mid-ACCESS SHALL abandon the transaction with no wait pulse.

Structure
REQ-039 The arbstate_t enum (IDLE, ACCESS) and the channel-class enum (ICLASS, DCLASS) SHALL live in the shared cpu_types_pkg.
REQ-040 One sub-module, rr_pick, SHALL compute the round-robin winner for one request vector against a pointer; it SHALL be instantiated twice, once per class.

Verification
REQ-041 NCORES=2, core0 iREN iaddr=0x100, ramrdy=1 -> iwait[0] low in cycle 2, iload[0]=ramload, ipointer=1.
REQ-042 core0 iREN and core1 dWEN daddr=0x200 dstore=0xDEADBEEF together -> core1 is served first with ramWEN=1 and ramaddr=0x200; core0 is served after one IDLE cycle.
REQ-043 Both cores hold dREN continuously, ramrdy=1 -> completions alternate 0,1,0,1 and the pointer wraps.
REQ-044 Granted core1 drops dREN while ramrdy=0 -> strobes low, no dwait pulse, pointer unchanged, FSM in IDLE.
REQ-045 nRST=0 during ACCESS with ramrdy=0 -> next cycle IDLE, all waits 1, strobes 0, pointers 0.
REQ-046 NCORES=4, dREN on cores 1 and 3 with dpointer=2 -> core3 is granted first, then core1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the core-to-memory arbiter: FSM states, channel classes
// and small helpers for round-robin pointer arithmetic.
package cpu_types_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arbstate_t;

   typedef enum logic {
      ICLASS = 1'b0,
      DCLASS = 1'b1
   } chclass_t;

   // Width of a core index / round-robin pointer; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // (a + b) mod n for a < n and b < n, without a divider.
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin picker: returns the first requester at or after ptr,
// scanning upward and wrapping at N.
module rr_pick
   import cpu_types_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
)(
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      logic [PW-1:0] k;
      valid = 1'b0;
      idx   = '0;
      k     = '0;
      for (int off = N - 1; off >= 0; off--) begin
         k = PW'(wrap_add(int'(ptr), off, N));
         if (req[k]) begin
            valid = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates per-core icache/dcache channels onto one memory port.
// Data requests beat instruction requests; each class has its own
// round-robin pointer. One transaction at a time: IDLE latches a grant,
// ACCESS forwards the granted channel live until ramrdy or a dropped request.
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NCORES = 2,
   parameter int AW     = 32,
   parameter int DW     = 32
)(
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NCORES-1:0]         iREN,
   input  logic [NCORES-1:0][AW-1:0] iaddr,
   input  logic [NCORES-1:0]         dREN,
   input  logic [NCORES-1:0]         dWEN,
   input  logic [NCORES-1:0][AW-1:0] daddr,
   input  logic [NCORES-1:0][DW-1:0] dstore,
   output logic [NCORES-1:0]         iwait,
   output logic [NCORES-1:0]         dwait,
   output logic [NCORES-1:0][DW-1:0] iload,
   output logic [NCORES-1:0][DW-1:0] dload,
   output logic                      ramREN,
   output logic                      ramWEN,
   output logic [AW-1:0]             ramaddr,
   output logic [DW-1:0]             ramstore,
   input  logic [DW-1:0]             ramload,
   input  logic                      ramrdy
);

   localparam int PW = ptr_width(NCORES);

   arbstate_t         state;
   chclass_t          grant_class;
   logic [PW-1:0]     grant_core;
   logic [PW-1:0]     ipointer;
   logic [PW-1:0]     dpointer;

   logic [NCORES-1:0] dreq;
   logic              ivalid;
   logic              dvalid;
   logic [PW-1:0]     iidx;
   logic [PW-1:0]     didx;

   logic              granted_active;
   logic              granted_write;
   logic              complete;
   logic [PW-1:0]     grant_next;

   genvar gi;

   generate
      for (gi = 0; gi < NCORES; gi++) begin : g_dreq
         assign dreq[gi] = dREN[gi] | dWEN[gi];
      end
   endgenerate

   rr_pick #(.N(NCORES), .PW(PW)) u_ipick (
      .req   (iREN),
      .ptr   (ipointer),
      .valid (ivalid),
      .idx   (iidx)
   );

   rr_pick #(.N(NCORES), .PW(PW)) u_dpick (
      .req   (dreq),
      .ptr   (dpointer),
      .valid (dvalid),
      .idx   (didx)
   );

   // Live view of the granted channel and the memory port it drives.
   always_comb begin
      granted_active = (grant_class == DCLASS) ? dreq[grant_core] : iREN[grant_core];
      granted_write  = (grant_class == DCLASS) && dWEN[grant_core];
      complete       = (state == ACCESS) && granted_active && ramrdy;
      grant_next     = (grant_core == PW'(NCORES - 1)) ? '0 : grant_core + 1'b1;

      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if ((state == ACCESS) && granted_active) begin
         if (grant_class == DCLASS) begin
            ramWEN  = granted_write;
            ramREN  = ~granted_write;
            ramaddr = daddr[grant_core];
            if (granted_write) ramstore = dstore[grant_core];
         end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr[grant_core];
         end
      end
   end

   // Arbitration FSM: grant in IDLE, finish or abort in ACCESS.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= IDLE;
         grant_class <= ICLASS;
         grant_core  <= '0;
         ipointer    <= '0;
         dpointer    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dvalid) begin
                  grant_class <= DCLASS;
                  grant_core  <= didx;
                  state       <= ACCESS;
               end else if (ivalid) begin
                  grant_class <= ICLASS;
                  grant_core  <= iidx;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (!granted_active) begin
                  state <= IDLE;
               end else if (ramrdy) begin
                  state <= IDLE;
                  if (grant_class == DCLASS) dpointer <= grant_next;
                  else                       ipointer <= grant_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Only the completing channel sees wait low and the memory data.
   generate
      for (gi = 0; gi < NCORES; gi++) begin : g_resp
         logic ihit;
         logic dhit;
         assign ihit      = complete && (grant_class == ICLASS) && (grant_core == PW'(gi));
         assign dhit      = complete && (grant_class == DCLASS) && (grant_core == PW'(gi));
         assign iwait[gi] = ~ihit;
         assign dwait[gi] = ~dhit;
         assign iload[gi] = ihit ? ramload : '0;
         assign dload[gi] = dhit ? ramload : '0;
      end
   endgenerate

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, negedge monitors
// pop and compare whenever a wait drops. A 2-core and a 4-core instance.
module tb_cache_mem_arbiter;

   localparam logic [31:0] K = 32'hA5A5_0000;

   typedef struct {
      bit          d;
      int          core;
      logic [31:0] addr;
      bit          wen;
      logic [31:0] store;
   } exp_t;

   exp_t q2[$];
   exp_t q4[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic clk = 1'b0;
   logic nrst;
   logic ramrdy;

   logic [1:0]        iren2, dren2, dwen2, iwait2, dwait2;
   logic [1:0][31:0]  iaddr2, daddr2, dstore2, iload2, dload2;
   logic              ramren2, ramwen2;
   logic [31:0]       ramaddr2, ramstore2, ramload2;

   logic [3:0]        iren4, dren4, dwen4, iwait4, dwait4;
   logic [3:0][31:0]  iaddr4, daddr4, dstore4, iload4, dload4;
   logic              ramren4, ramwen4;
   logic [31:0]       ramaddr4, ramstore4, ramload4;

   always #5 clk = ~clk;

   assign ramload2 = ramaddr2 ^ K;
   assign ramload4 = ramaddr4 ^ K;

   cache_mem_arbiter #(.NCORES(2), .AW(32), .DW(32)) dut2 (
      .CLK(clk), .nRST(nrst),
      .iREN(iren2), .iaddr(iaddr2), .dREN(dren2), .dWEN(dwen2),
      .daddr(daddr2), .dstore(dstore2),
      .iwait(iwait2), .dwait(dwait2), .iload(iload2), .dload(dload2),
      .ramREN(ramren2), .ramWEN(ramwen2), .ramaddr(ramaddr2),
      .ramstore(ramstore2), .ramload(ramload2), .ramrdy(ramrdy)
   );

   cache_mem_arbiter #(.NCORES(4), .AW(32), .DW(32)) dut4 (
      .CLK(clk), .nRST(nrst),
      .iREN(iren4), .iaddr(iaddr4), .dREN(dren4), .dWEN(dwen4),
      .daddr(daddr4), .dstore(dstore4),
      .iwait(iwait4), .dwait(dwait4), .iload(iload4), .dload(dload4),
      .ramREN(ramren4), .ramWEN(ramwen4), .ramaddr(ramaddr4),
      .ramstore(ramstore4), .ramload(ramload4), .ramrdy(ramrdy)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Compare one observed completion against the head of the scoreboard.
   task automatic on_done(input int inst, input bit d, input int core,
                          input logic [31:0] load, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] store);
      exp_t e;
      if ((inst == 0 && q2.size() == 0) || (inst != 0 && q4.size() == 0)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_done: inst %0d class %0d core %0d addr %0h, none expected",
                  inst, d, core, addr);
         return;
      end
      if (inst == 0) e = q2.pop_front();
      else           e = q4.pop_front();
      $display("txn inst=%0d class=%s core=%0d addr=%0h wen=%0b store=%0h load=%0h",
               inst, d ? "D" : "I", core, addr, wen, store, load);
      check("done_channel", {31'd0, d, core}, {31'd0, e.d, e.core});
      check("done_addr",  addr,  e.addr);
      check("done_wen",   wen,   e.wen);
      check("done_ren",   ren,   !e.wen);
      check("done_store", store, e.store);
      check("done_load",  load,  e.addr ^ K);
   endtask

   always @(negedge clk) begin
      logic [31:0] spare;
      spare = '0;
      for (int c = 0; c < 2; c++) begin
         if (iwait2[c] === 1'b0) on_done(0, 1'b0, c, iload2[c], ramren2, ramwen2, ramaddr2, ramstore2);
         else spare = spare | iload2[c];
         if (dwait2[c] === 1'b0) on_done(0, 1'b1, c, dload2[c], ramren2, ramwen2, ramaddr2, ramstore2);
         else spare = spare | dload2[c];
      end
      check("idle_loads2", spare, 0);
   end

   always @(negedge clk) begin
      logic [31:0] spare;
      spare = '0;
      for (int c = 0; c < 4; c++) begin
         if (iwait4[c] === 1'b0) on_done(1, 1'b0, c, iload4[c], ramren4, ramwen4, ramaddr4, ramstore4);
         else spare = spare | iload4[c];
         if (dwait4[c] === 1'b0) on_done(1, 1'b1, c, dload4[c], ramren4, ramwen4, ramaddr4, ramstore4);
         else spare = spare | dload4[c];
      end
      check("idle_loads4", spare, 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_done(input int inst, input bit d, input int core);
      if (inst == 0) return d ? !dwait2[core] : !iwait2[core];
      return d ? !dwait4[core] : !iwait4[core];
   endfunction

   // Count negedges until the given channel completes; bounded.
   task automatic wait_done(input int inst, input bit d, input int core, output int n);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n++;
         if (is_done(inst, d, core)) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout: inst %0d class %0d core %0d got no completion, required within 20 cycles",
               inst, d, core);
   endtask

   initial begin
      int n;
      nrst = 1'b0;
      ramrdy = 1'b0;
      iren2 = '0; dren2 = '0; dwen2 = '0; iaddr2 = '0; daddr2 = '0; dstore2 = '0;
      iren4 = '0; dren4 = '0; dwen4 = '0; iaddr4 = '0; daddr4 = '0; dstore4 = '0;
      step();
      step();

      // Reset state
      @(negedge clk);
      check("rst_iwait2", iwait2, 2'b11);
      check("rst_dwait2", dwait2, 2'b11);
      check("rst_strobes2", {ramren2, ramwen2}, 0);
      check("rst_ramaddr2", ramaddr2, 0);
      check("rst_ramstore2", ramstore2, 0);
      check("rst_loads2", {iload2, dload2}, 0);
      check("rst_waits4", {iwait4, dwait4}, 8'hFF);
      check("rst_ptrs2", {dut2.ipointer, dut2.dpointer}, 0);
      step();
      nrst = 1'b1;

      // Single instruction fetch, 2-cycle latency
      ramrdy = 1'b1;
      iaddr2[0] = 32'h100;
      iren2[0] = 1'b1;
      q2.push_back('{1'b0, 0, 32'h100, 1'b0, 32'h0});
      wait_done(0, 1'b0, 0, n);
      check("t1_latency", n, 2);
      step();
      iren2[0] = 1'b0;
      check("t1_ipointer", dut2.ipointer, 1);

      // Data write beats instruction fetch; fetch follows after one IDLE cycle
      iaddr2[0] = 32'h104;
      iren2[0] = 1'b1;
      daddr2[1] = 32'h200;
      dstore2[1] = 32'hDEADBEEF;
      dwen2[1] = 1'b1;
      q2.push_back('{1'b1, 1, 32'h200, 1'b1, 32'hDEADBEEF});
      q2.push_back('{1'b0, 0, 32'h104, 1'b0, 32'h0});
      wait_done(0, 1'b1, 1, n);
      check("t2_d_latency", n, 2);
      step();
      dwen2[1] = 1'b0;
      wait_done(0, 1'b0, 0, n);
      check("t2_i_gap", n, 2);
      step();
      iren2[0] = 1'b0;
      check("t2_dpointer", dut2.dpointer, 0);
      check("t2_ipointer", dut2.ipointer, 1);

      // Two cores hammering dREN alternate and the pointer wraps
      daddr2[0] = 32'h300;
      daddr2[1] = 32'h304;
      dren2 = 2'b11;
      for (int k = 0; k < 4; k++)
         q2.push_back('{1'b1, k % 2, (k % 2) ? 32'h304 : 32'h300, 1'b0, 32'h0});
      for (int k = 0; k < 4; k++) begin
         wait_done(0, 1'b1, k % 2, n);
         check("t3_latency", n, 2);
         step();
         check("t3_dpointer", dut2.dpointer, (k % 2 == 0) ? 1 : 0);
      end
      dren2 = 2'b00;

      // Move dpointer to 1 so the abort below can show it is untouched
      daddr2[0] = 32'h308;
      dren2[0] = 1'b1;
      q2.push_back('{1'b1, 0, 32'h308, 1'b0, 32'h0});
      wait_done(0, 1'b1, 0, n);
      step();
      dren2[0] = 1'b0;
      check("t4_pre_dpointer", dut2.dpointer, 1);

      // Abort: granted core1 drops dREN while memory is busy
      ramrdy = 1'b0;
      daddr2[1] = 32'h400;
      dren2[1] = 1'b1;
      step();
      @(negedge clk);
      check("t4_state_access", dut2.state, 1);
      check("t4_ramren", ramren2, 1);
      check("t4_ramaddr", ramaddr2, 32'h400);
      step();
      dren2[1] = 1'b0;
      @(negedge clk);
      check("t4_strobes_low", {ramren2, ramwen2}, 0);
      check("t4_no_pulse", dwait2, 2'b11);
      step();
      check("t4_state_idle", dut2.state, 0);
      check("t4_dpointer", dut2.dpointer, 1);

      // Reset in the middle of an access
      iaddr2[0] = 32'h500;
      iren2[0] = 1'b1;
      step();
      @(negedge clk);
      check("t5_state_access", dut2.state, 1);
      step();
      nrst = 1'b0;
      step();
      check("t5_state_idle", dut2.state, 0);
      check("t5_ptrs", {dut2.ipointer, dut2.dpointer}, 0);
      @(negedge clk);
      check("t5_waits", {iwait2, dwait2}, 4'hF);
      check("t5_strobes", {ramren2, ramwen2}, 0);
      iren2[0] = 1'b0;
      step();
      nrst = 1'b1;

      // dREN and dWEN together count as a write
      ramrdy = 1'b1;
      daddr2[0] = 32'h600;
      dstore2[0] = 32'h12345678;
      dren2[0] = 1'b1;
      dwen2[0] = 1'b1;
      q2.push_back('{1'b1, 0, 32'h600, 1'b1, 32'h12345678});
      wait_done(0, 1'b1, 0, n);
      check("t6_latency", n, 2);
      step();
      dren2[0] = 1'b0;
      dwen2[0] = 1'b0;
      check("t6_dpointer", dut2.dpointer, 1);

      // 4 cores: with dpointer at 2, core3 wins before core1
      daddr4[1] = 32'h710;
      dren4[1] = 1'b1;
      q4.push_back('{1'b1, 1, 32'h710, 1'b0, 32'h0});
      wait_done(1, 1'b1, 1, n);
      step();
      dren4[1] = 1'b0;
      check("t7_dpointer_setup", dut4.dpointer, 2);
      daddr4[1] = 32'h720;
      daddr4[3] = 32'h730;
      dren4[1] = 1'b1;
      dren4[3] = 1'b1;
      q4.push_back('{1'b1, 3, 32'h730, 1'b0, 32'h0});
      q4.push_back('{1'b1, 1, 32'h720, 1'b0, 32'h0});
      wait_done(1, 1'b1, 3, n);
      check("t7_core3_latency", n, 2);
      step();
      dren4[3] = 1'b0;
      check("t7_dpointer_wrap", dut4.dpointer, 0);
      wait_done(1, 1'b1, 1, n);
      check("t7_core1_latency", n, 2);
      step();
      dren4[1] = 1'b0;
      check("t7_dpointer_end", dut4.dpointer, 2);

      step();
      step();
      check("scoreboard_drained", q2.size() + q4.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
